// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
// Purpose : bundles the VGA timing outputs of vga_sync_gen so the generator
//           and its consumers (game logic, connector pins) share one port.
// Signals : o_HSync, o_VSync      - sync pulses at the generator's polarity
//           o_Col_Count/o_Row_Count - 10-bit current pixel position
//           o_Active              - position lies in the visible window
//           o_Line_Start          - one-tick strobe at column 0
//           o_Frame_Start         - one-tick strobe at column 0, row 0
//           o_Frame_Count         - 8-bit frame counter, present only when
//                                   VGA_SYNC_GEN_FRAME_COUNT_EN is defined
// Modports: master = generator (drives), slave = consumer (reads).
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
   logic       o_HSync;
   logic       o_VSync;
   logic [9:0] o_Col_Count;
   logic [9:0] o_Row_Count;
   logic       o_Active;
   logic       o_Line_Start;
   logic       o_Frame_Start;
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
   logic [7:0] o_Frame_Count;
`endif

   modport master (
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
      output o_Frame_Count,
`endif
      output o_HSync, output o_VSync, output o_Col_Count, output o_Row_Count,
      output o_Active, output o_Line_Start, output o_Frame_Start
   );

   modport slave (
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
      input o_Frame_Count,
`endif
      input o_HSync, input o_VSync, input o_Col_Count, input o_Row_Count,
      input o_Active, input o_Line_Start, input o_Frame_Start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Purpose : VGA timing generator. Walks a (col,row) raster one position per
//           enabled clock and produces sync pulses, active-video flag and
//           line/frame start strobes, all registered and describing the same
//           (col,row) on every cycle.
// Ports   : i_Clk    - system clock
//           i_Rst    - asynchronous reset, active-high
//           i_Enable - pixel tick; every register holds while it is low
//           o_Vga    - vga_sync_gen_if.master carrying all timing outputs
// Options : define VGA_SYNC_GEN_FRAME_COUNT_EN to add the 8-bit o_Frame_Count
//           output (counts frame starts after the first, wraps 255 -> 0).
// -----------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int unsigned c_ACTIVE_COLS   = 640,
   parameter int unsigned c_H_FRONT_PORCH = 16,
   parameter int unsigned c_H_SYNC_WIDTH  = 96,
   parameter int unsigned c_H_BACK_PORCH  = 48,
   parameter int unsigned c_ACTIVE_ROWS   = 480,
   parameter int unsigned c_V_FRONT_PORCH = 10,
   parameter int unsigned c_V_SYNC_WIDTH  = 2,
   parameter int unsigned c_V_BACK_PORCH  = 33,
   parameter bit          c_SYNC_POL      = 1'b0
) (
   input  logic           i_Clk,
   input  logic           i_Rst,
   input  logic           i_Enable,
   vga_sync_gen_if.master o_Vga
);

   localparam int unsigned c_TOTAL_COLS =
      c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH + c_H_BACK_PORCH;
   localparam int unsigned c_TOTAL_ROWS =
      c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH + c_V_BACK_PORCH;

   // Last column / row of each phase; a phase ends when the counter sits here.
   localparam logic [9:0] c_H_ACT_LAST  = 10'(c_ACTIVE_COLS - 32'd1);
   localparam logic [9:0] c_H_FP_LAST   = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH - 32'd1);
   localparam logic [9:0] c_H_SYNC_LAST = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH - 32'd1);
   localparam logic [9:0] c_COL_LAST    = 10'(c_TOTAL_COLS - 32'd1);
   localparam logic [9:0] c_V_ACT_LAST  = 10'(c_ACTIVE_ROWS - 32'd1);
   localparam logic [9:0] c_V_FP_LAST   = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH - 32'd1);
   localparam logic [9:0] c_V_SYNC_LAST = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH - 32'd1);
   localparam logic [9:0] c_ROW_LAST    = 10'(c_TOTAL_ROWS - 32'd1);

   generate
      if (c_ACTIVE_COLS == 32'd0 || c_H_FRONT_PORCH == 32'd0 || c_H_SYNC_WIDTH == 32'd0 ||
          c_H_BACK_PORCH == 32'd0 || c_ACTIVE_ROWS == 32'd0 || c_V_FRONT_PORCH == 32'd0 ||
          c_V_SYNC_WIDTH == 32'd0 || c_V_BACK_PORCH == 32'd0 ||
          c_TOTAL_COLS > 32'd1024 || c_TOTAL_ROWS > 32'd1024) begin : g_bad_params
         $error("vga_sync_gen: timing parameters must be non-zero and totals <= 1024");
      end
   endgenerate

   typedef enum logic       {S_IDLE = 1'b0, S_RUN = 1'b1} top_state_t;
   typedef enum logic [1:0] {H_ACTIVE = 2'd0, H_FP = 2'd1, H_SYNC = 2'd2, H_BP = 2'd3} h_state_t;
   typedef enum logic [1:0] {V_ACTIVE = 2'd0, V_FP = 2'd1, V_SYNC = 2'd2, V_BP = 2'd3} v_state_t;

   top_state_t r_state,   w_state_nxt;
   h_state_t   r_h_state, w_h_state_nxt;
   v_state_t   r_v_state, w_v_state_nxt;
   logic [9:0] r_col, w_col_nxt;
   logic [9:0] r_row, w_row_nxt;
   logic       r_hsync, w_hsync_nxt;
   logic       r_vsync, w_vsync_nxt;
   logic       r_active, w_active_nxt;
   logic       r_line_start, w_line_start_nxt;
   logic       r_frame_start, w_frame_start_nxt;
   logic       w_col_wrap;

   assign w_col_wrap = (r_state == S_RUN) && (r_col == c_COL_LAST);

   // State, position and registered outputs; all hold while i_Enable is low.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_state       <= S_IDLE;
         r_h_state     <= H_ACTIVE;
         r_v_state     <= V_ACTIVE;
         r_col         <= 10'd0;
         r_row         <= 10'd0;
         r_hsync       <= ~c_SYNC_POL;
         r_vsync       <= ~c_SYNC_POL;
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (i_Enable) begin
         r_state       <= w_state_nxt;
         r_h_state     <= w_h_state_nxt;
         r_v_state     <= w_v_state_nxt;
         r_col         <= w_col_nxt;
         r_row         <= w_row_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_active      <= w_active_nxt;
         r_line_start  <= w_line_start_nxt;
         r_frame_start <= w_frame_start_nxt;
      end
   end

   // Top FSM next state: leave IDLE on the first enabled tick, then run forever.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = i_Enable ? S_RUN : S_IDLE;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next raster position; leaving IDLE lands on (0,0).
   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (r_state == S_RUN) begin
         if (w_col_wrap) begin
            w_col_nxt = 10'd0;
            w_row_nxt = (r_row == c_ROW_LAST) ? 10'd0 : (r_row + 10'd1);
         end else begin
            w_col_nxt = r_col + 10'd1;
            w_row_nxt = r_row;
         end
      end else begin
         w_col_nxt = 10'd0;
         w_row_nxt = 10'd0;
      end
   end

   // Horizontal phase FSM: each phase ends on its last column.
   always_comb begin
      w_h_state_nxt = r_h_state;
      if (r_state == S_RUN) begin
         case (r_h_state)
            H_ACTIVE: w_h_state_nxt = (r_col == c_H_ACT_LAST)  ? H_FP   : H_ACTIVE;
            H_FP:     w_h_state_nxt = (r_col == c_H_FP_LAST)   ? H_SYNC : H_FP;
            H_SYNC:   w_h_state_nxt = (r_col == c_H_SYNC_LAST) ? H_BP   : H_SYNC;
            H_BP:     w_h_state_nxt = w_col_wrap ? H_ACTIVE : H_BP;
            default:  w_h_state_nxt = H_ACTIVE;
         endcase
      end else begin
         w_h_state_nxt = H_ACTIVE;
      end
   end

   // Vertical phase FSM: moves only on a column wrap out of a phase's last row.
   always_comb begin
      w_v_state_nxt = r_v_state;
      if (w_col_wrap) begin
         case (r_v_state)
            V_ACTIVE: w_v_state_nxt = (r_row == c_V_ACT_LAST)  ? V_FP   : V_ACTIVE;
            V_FP:     w_v_state_nxt = (r_row == c_V_FP_LAST)   ? V_SYNC : V_FP;
            V_SYNC:   w_v_state_nxt = (r_row == c_V_SYNC_LAST) ? V_BP   : V_SYNC;
            V_BP:     w_v_state_nxt = (r_row == c_ROW_LAST)    ? V_ACTIVE : V_BP;
            default:  w_v_state_nxt = V_ACTIVE;
         endcase
      end else if (r_state != S_RUN) begin
         w_v_state_nxt = V_ACTIVE;
      end else begin
         w_v_state_nxt = r_v_state;
      end
   end

   // Output decode from the next phase/position so outputs and counters stay aligned.
   always_comb begin
      w_hsync_nxt       = (w_h_state_nxt == H_SYNC) ? c_SYNC_POL : ~c_SYNC_POL;
      w_vsync_nxt       = (w_v_state_nxt == V_SYNC) ? c_SYNC_POL : ~c_SYNC_POL;
      w_active_nxt      = (w_h_state_nxt == H_ACTIVE) && (w_v_state_nxt == V_ACTIVE);
      w_line_start_nxt  = (w_col_nxt == 10'd0);
      w_frame_start_nxt = (w_col_nxt == 10'd0) && (w_row_nxt == 10'd0);
   end

   assign o_Vga.o_HSync       = r_hsync;
   assign o_Vga.o_VSync       = r_vsync;
   assign o_Vga.o_Col_Count   = r_col;
   assign o_Vga.o_Row_Count   = r_row;
   assign o_Vga.o_Active      = r_active;
   assign o_Vga.o_Line_Start  = r_line_start;
   assign o_Vga.o_Frame_Start = r_frame_start;

`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
   logic [7:0] r_frame_cnt;
   logic       r_first_seen;

   // Frame counter: the first frame after reset is frame 0, later starts count up.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_frame_cnt  <= 8'd0;
         r_first_seen <= 1'b0;
      end else if (i_Enable && w_frame_start_nxt) begin
         if (r_first_seen) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end else begin
            r_first_seen <= 1'b1;
         end
      end
   end

   assign o_Vga.o_Frame_Count = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one default-timing instance (active-low sync) and one
// small-raster instance (active-high sync) so whole frames fit in a short run.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, en_a, en_b;
   logic chk_on = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   vga_sync_gen_if if_a ();
   vga_sync_gen_if if_b ();

   vga_sync_gen dut_a (.i_Clk(clk), .i_Rst(rst_a), .i_Enable(en_a), .o_Vga(if_a));

   vga_sync_gen #(
      .c_ACTIVE_COLS(8), .c_H_FRONT_PORCH(2), .c_H_SYNC_WIDTH(3), .c_H_BACK_PORCH(2),
      .c_ACTIVE_ROWS(4), .c_V_FRONT_PORCH(2), .c_V_SYNC_WIDTH(2), .c_V_BACK_PORCH(3),
      .c_SYNC_POL(1'b1)
   ) dut_b (.i_Clk(clk), .i_Rst(rst_b), .i_Enable(en_b), .o_Vga(if_b));

   localparam int FRAME_A = 800 * 525;
   localparam int FRAME_B = 15 * 11;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [9:0] col;
      logic [9:0] row;
      logic       act;
      logic       ls;
      logic       fs;
   } exp_t;

   // Reference model: position = enabled ticks since the frame began (-1 = idle).
   int pos_a = -1;
   int pos_b = -1;
   int frames_b = 0;

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) pos_a <= -1;
      else if (en_a) pos_a <= (pos_a + 1) % FRAME_A;
   end

   always @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         pos_b    <= -1;
         frames_b <= 0;
      end else if (en_b) begin
         pos_b <= (pos_b + 1) % FRAME_B;
         if ((pos_b + 1) % FRAME_B == 0) frames_b <= frames_b + 1;
      end
   end

   function automatic exp_t f_exp(input int pos, input int ac, input int hfp, input int hsw,
                                  input int hbp, input int ar, input int vfp, input int vsw,
                                  input logic pol);
      exp_t e;
      int   tc, col, row;
      tc = ac + hfp + hsw + hbp;
      if (pos < 0) begin
         e = '0;
         e.hs = ~pol;
         e.vs = ~pol;
      end else begin
         col   = pos % tc;
         row   = pos / tc;
         e.col = col[9:0];
         e.row = row[9:0];
         e.hs  = (col >= ac + hfp && col < ac + hfp + hsw) ? pol : ~pol;
         e.vs  = (row >= ar + vfp && row < ar + vfp + vsw) ? pol : ~pol;
         e.act = (col < ac) && (row < ar);
         e.ls  = (col == 0);
         e.fs  = (pos == 0);
      end
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_out(input string tag, input logic hs, input logic vs, input logic [9:0] col,
                          input logic [9:0] row, input logic act, input logic ls, input logic fs,
                          input exp_t e);
      cmp({tag, "_hsync"}, 32'(hs), 32'(e.hs));
      cmp({tag, "_vsync"}, 32'(vs), 32'(e.vs));
      cmp({tag, "_col"}, 32'(col), 32'(e.col));
      cmp({tag, "_row"}, 32'(row), 32'(e.row));
      cmp({tag, "_active"}, 32'(act), 32'(e.act));
      cmp({tag, "_line_start"}, 32'(ls), 32'(e.ls));
      cmp({tag, "_frame_start"}, 32'(fs), 32'(e.fs));
   endtask

   // Every-cycle comparison of both instances against the model, on the falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         cmp_out("a", if_a.o_HSync, if_a.o_VSync, if_a.o_Col_Count, if_a.o_Row_Count,
                 if_a.o_Active, if_a.o_Line_Start, if_a.o_Frame_Start,
                 f_exp(pos_a, 640, 16, 96, 48, 480, 10, 2, 1'b0));
         cmp_out("b", if_b.o_HSync, if_b.o_VSync, if_b.o_Col_Count, if_b.o_Row_Count,
                 if_b.o_Active, if_b.o_Line_Start, if_b.o_Frame_Start,
                 f_exp(pos_b, 8, 2, 3, 2, 4, 2, 2, 1'b1));
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
         cmp("b_frame_count", 32'(if_b.o_Frame_Count),
             (frames_b == 0) ? 32'd0 : 32'((frames_b - 1) % 256));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int hs_cnt, hs_first, act_fall, ls_cnt, vs_cnt, act_blank, period, nfs, r1, r2;
      logic prev_fs;
      rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
      #1;
      rst_a = 1'b1; rst_b = 1'b1;
      cyc(); cyc();
      chk_on = 1'b1;

      // Reset values
      cmp("rst_a_col", 32'(if_a.o_Col_Count), 32'd0);
      cmp("rst_a_hsync", 32'(if_a.o_HSync), 32'd1);
      cmp("rst_a_active", 32'(if_a.o_Active), 32'd0);
      cmp("rst_a_frame_start", 32'(if_a.o_Frame_Start), 32'd0);
      cmp("rst_b_hsync", 32'(if_b.o_HSync), 32'd0);

      // First enabled tick after reset release
      rst_a = 1'b0; en_a = 1'b1;
      cyc();
      cmp("first_col", 32'(if_a.o_Col_Count), 32'd0);
      cmp("first_row", 32'(if_a.o_Row_Count), 32'd0);
      cmp("first_active", 32'(if_a.o_Active), 32'd1);
      cmp("first_frame_start", 32'(if_a.o_Frame_Start), 32'd1);
      cmp("first_line_start", 32'(if_a.o_Line_Start), 32'd1);

      // One full line of horizontal timing
      hs_cnt = 0; hs_first = -1; act_fall = -1; ls_cnt = 0;
      for (int t = 1; t <= 800; t++) begin
         cyc();
         if (if_a.o_HSync == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(if_a.o_Col_Count);
         end
         if (!if_a.o_Active && act_fall < 0) act_fall = int'(if_a.o_Col_Count);
         if (if_a.o_Line_Start) ls_cnt++;
      end
      cmp("line_hsync_ticks", 32'(hs_cnt), 32'd96);
      cmp("line_hsync_first_col", 32'(hs_first), 32'd656);
      cmp("line_active_fall_col", 32'(act_fall), 32'd640);
      cmp("line_start_count", 32'(ls_cnt), 32'd1);
      cmp("line_end_row", 32'(if_a.o_Row_Count), 32'd1);

      // Enable toggled every other clock: sync width doubles in clocks
      hs_cnt = 0;
      for (int k = 1; k <= 1600; k++) begin
         en_a = (k % 2 == 1);
         cyc();
         if (if_a.o_HSync == 1'b0) hs_cnt++;
      end
      cmp("toggle_hsync_clocks", 32'(hs_cnt), 32'd192);
      cmp("toggle_end_col", 32'(if_a.o_Col_Count), 32'd0);

      // Asynchronous reset mid-line
      en_a = 1'b1;
      for (int k = 0; k < 300; k++) cyc();
      cmp("pre_rst_col", 32'(if_a.o_Col_Count), 32'd300);
      cmp("pre_rst_row", 32'(if_a.o_Row_Count), 32'd2);
      rst_a = 1'b1;
      #1;
      cmp("async_rst_col", 32'(if_a.o_Col_Count), 32'd0);
      cmp("async_rst_row", 32'(if_a.o_Row_Count), 32'd0);
      cmp("async_rst_hsync", 32'(if_a.o_HSync), 32'd1);
      cmp("async_rst_active", 32'(if_a.o_Active), 32'd0);
      cyc();
      rst_a = 1'b0;
      cyc();
      cmp("restart_col", 32'(if_a.o_Col_Count), 32'd0);
      cmp("restart_frame_start", 32'(if_a.o_Frame_Start), 32'd1);
      en_a = 1'b0;

      // Small raster: frame period, vertical windows, frame counter
      rst_b = 1'b0; en_b = 1'b1;
      cyc();
      cmp("b_first_frame_start", 32'(if_b.o_Frame_Start), 32'd1);
      cmp("b_first_hsync", 32'(if_b.o_HSync), 32'd0);
      nfs = 1; vs_cnt = 0; act_blank = 0; period = -1;
      for (int t = 1; t <= 256 * FRAME_B + 10 && nfs < 257; t++) begin
         cyc();
         if (t < FRAME_B) begin
            if (if_b.o_VSync == 1'b1) vs_cnt++;
            if (if_b.o_Active && if_b.o_Row_Count >= 10'd4) act_blank++;
         end
         if (if_b.o_Frame_Start) begin
            nfs++;
            if (nfs == 2) period = t;
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
            if (nfs == 4) cmp("fc_fourth_frame", 32'(if_b.o_Frame_Count), 32'd3);
            if (nfs == 257) cmp("fc_wrap", 32'(if_b.o_Frame_Count), 32'd0);
`endif
         end
      end
      cmp("b_vsync_ticks", 32'(vs_cnt), 32'd30);
      cmp("b_active_in_vblank", 32'(act_blank), 32'd0);
      cmp("b_frame_period", 32'(period), 32'(FRAME_B));
      cmp("b_frames_seen", 32'(nfs), 32'd257);

      // Small raster with enable toggled: period and VSync width double
      r1 = -1; r2 = -1; vs_cnt = 0; prev_fs = if_b.o_Frame_Start;
      for (int k = 1; k <= 700; k++) begin
         en_b = (k % 2 == 1);
         cyc();
         if (if_b.o_Frame_Start && !prev_fs) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) r2 = k;
         end
         if (r1 >= 0 && r2 < 0 && if_b.o_VSync == 1'b1) vs_cnt++;
         prev_fs = if_b.o_Frame_Start;
      end
      cmp("b_toggle_period", 32'(r2 - r1), 32'(2 * FRAME_B));
      cmp("b_toggle_vsync_clocks", 32'(vs_cnt), 32'd60);

      // Randomized enable and occasional resets, checked by the model every cycle
      for (int k = 0; k < 4000; k++) begin
         en_a  = ($urandom_range(0, 3) != 0);
         en_b  = ($urandom_range(0, 3) != 0);
         rst_a = ($urandom_range(0, 599) == 0);
         rst_b = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst_a = 1'b0; rst_b = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
